snake_state_engine: RTL



---
 rtl/snake_state_engine.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/snake_state_engine.sv
// Snake game-state engine: owns the body, food cell and win/lose status, one move per Tick.
// Build option WRAP_EN: grid edges wrap (modulo 16) instead of ending the game.
// states: INIT idle/initial board | PLAY moving | PLACE searching a food cell | WIN | LOSE
module snake_state_engine #(
  parameter int         INIT_LEN   = 3,
  parameter int         MAX_LEN    = 15,
  parameter logic [7:0] START_HEAD = 8'h88,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Tick,
  input  logic         Start,
  input  logic         BtnU,
  input  logic         BtnD,
  input  logic         BtnL,
  input  logic         BtnR,
  output logic [127:0] Locations_Flat,
  output logic [3:0]   Length,
  output logic [7:0]   Food,
  output logic         Qi,
  output logic         Qc,
  output logic         Qw,
  output logic         Ql
);

  typedef enum logic [2:0] {ST_INIT, ST_PLAY, ST_PLACE, ST_WIN, ST_LOSE} state_t;
  typedef enum logic [1:0] {DIR_U, DIR_D, DIR_L, DIR_R} dir_t;

  state_t     state_q, state_d;
  dir_t       dir_q, dir_d;
  dir_t       pend_q, pend_d;
  logic [7:0] seg_q [16];
  logic [7:0] seg_d [16];
  logic [3:0] len_q, len_d;
  logic [7:0] food_q, food_d;
  logic [7:0] lfsr_q, lfsr_d;

  logic [3:0] row, col, nrow, ncol;
  logic [7:0] head_nxt;
  logic       wall, eat, self_hit, occupied;
  logic       btn_any, btn_ok;
  dir_t       btn_dir, dir_ref;

  function automatic logic [7:0] init_seg(input int k);
    return (k < INIT_LEN) ? 8'(int'(START_HEAD) - k) : 8'h00;
  endfunction

  function automatic dir_t opposite(input dir_t d);
    case (d)
      DIR_U:   return DIR_D;
      DIR_D:   return DIR_U;
      DIR_L:   return DIR_R;
      default: return DIR_L;
    endcase
  endfunction

  // x^8 + x^6 + x^5 + x^4 + 1, free-running in every state
  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_comb begin
    row  = seg_q[0][7:4];
    col  = seg_q[0][3:0];
    nrow = row;
    ncol = col;
    wall = 1'b0;
    case (pend_q)
      DIR_U: begin
        nrow = row - 4'd1;
        wall = (row == 4'd0);
      end
      DIR_D: begin
        nrow = row + 4'd1;
        wall = (row == 4'hF);
      end
      DIR_L: begin
        ncol = col - 4'd1;
        wall = (col == 4'd0);
      end
      default: begin
        ncol = col + 4'd1;
        wall = (col == 4'hF);
      end
    endcase
`ifdef WRAP_EN
    wall = 1'b0;
`endif
    head_nxt = {nrow, ncol};
  end

  // The tail vacates on a plain move, so it only counts as an obstacle when eating.
  always_comb begin
    eat      = (head_nxt == food_q);
    self_hit = 1'b0;
    occupied = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (({1'b0, 4'(k)} + (eat ? 5'd0 : 5'd1) < {1'b0, len_q}) && (seg_q[k] == head_nxt))
        self_hit = 1'b1;
      if ((4'(k) < len_q) && (seg_q[k] == lfsr_q))
        occupied = 1'b1;
    end
  end

  always_comb begin
    btn_any = BtnU | BtnD | BtnL | BtnR;
    if (BtnU)      btn_dir = DIR_U;
    else if (BtnD) btn_dir = DIR_D;
    else if (BtnL) btn_dir = DIR_L;
    else           btn_dir = DIR_R;
    dir_ref = (state_q == ST_PLAY && Tick) ? pend_q : dir_q;
    btn_ok  = btn_any && (btn_dir != opposite(dir_ref));
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    pend_d  = pend_q;
    len_d   = len_q;
    food_d  = food_q;
    for (int k = 0; k < 16; k++) seg_d[k] = seg_q[k];

    case (state_q)
      ST_INIT: begin
        if (Start) state_d = ST_PLACE;
      end
      ST_PLAY: begin
        if (Tick) begin
          dir_d = pend_q;
          if (wall || self_hit) begin
            state_d = ST_LOSE;
          end else begin
            seg_d[0] = head_nxt;
            for (int k = 1; k < 16; k++)
              seg_d[k] = ({1'b0, 4'(k)} < ({1'b0, len_q} + {4'b0, eat})) ? seg_q[k-1] : 8'h00;
            if (eat) begin
              len_d   = len_q + 4'd1;
              state_d = ((len_q + 4'd1) == 4'(MAX_LEN)) ? ST_WIN : ST_PLACE;
            end
          end
        end
        if (btn_ok) pend_d = btn_dir;
      end
      ST_PLACE: begin
        if (!occupied) begin
          food_d  = lfsr_q;
          state_d = ST_PLAY;
        end
        if (btn_ok) pend_d = btn_dir;
      end
      ST_WIN, ST_LOSE: begin
        if (Start) begin
          state_d = ST_INIT;
          dir_d   = DIR_R;
          pend_d  = DIR_R;
          len_d   = 4'(INIT_LEN);
          food_d  = 8'h00;
          for (int k = 0; k < 16; k++) seg_d[k] = init_seg(k);
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_INIT;
      dir_q   <= DIR_R;
      pend_q  <= DIR_R;
      len_q   <= 4'(INIT_LEN);
      food_q  <= 8'h00;
      lfsr_q  <= LFSR_SEED;
      for (int k = 0; k < 16; k++) seg_q[k] <= init_seg(k);
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      pend_q  <= pend_d;
      len_q   <= len_d;
      food_q  <= food_d;
      lfsr_q  <= lfsr_d;
      for (int k = 0; k < 16; k++) seg_q[k] <= seg_d[k];
    end
  end

  always_comb begin
    Locations_Flat = '0;
    for (int k = 0; k < 16; k++) Locations_Flat[127-8*k -: 8] = seg_q[k];
  end

  assign Length = len_q;
  assign Food   = food_q;
  assign Qi     = (state_q == ST_INIT);
  assign Qc     = (state_q == ST_PLAY) || (state_q == ST_PLACE);
  assign Qw     = (state_q == ST_WIN);
  assign Ql     = (state_q == ST_LOSE);

endmodule
